cms_sample_driver: RTL and testbench

Initiator-side driver for the `ComplexMeanSquare` unit. It buffers host-supplied (y, y_hat) sample pairs in a small FIFO and launches a run of 2^log2n samples. It answers each `next_number` request with the next buffered pair and returns the 64-bit result to the host through a valid/ready register. It sits between the host/DMA stream and the CMS unit and owns `start`, `log2n`, `y` and `y_hat`.

---
 rtl/cms_pkg.sv | 20 ++
 rtl/cms_sample_driver_if.sv | 39 +++
 rtl/cms_pair_fifo.sv | 60 ++++++
 rtl/cms_sample_driver.sv | 129 ++++++++++++
 tb/tb_cms_sample_driver.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cms_pkg.sv
// Shared widths, FSM state type and run-length helper for the CMS sample driver.
package cms_pkg;

   localparam int SAMPLE_W = 32;
   localparam int RESULT_W = 64;
   localparam int LOG2N_W  = 3;
   localparam int REQ_W    = 8;
   localparam int PAIR_W   = 2 * SAMPLE_W;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of samples in a run, one bit wider than the request counter.
   function automatic logic [REQ_W:0] run_len(input logic [LOG2N_W-1:0] i_log2n);
      return {{REQ_W{1'b0}}, 1'b1} << i_log2n;
   endfunction

endpackage

// File: rtl/cms_sample_driver_if.sv
// Host stream, command/result and CMS-side signals of the sample driver.
interface cms_sample_driver_if;
   import cms_pkg::*;

   logic                cmd_start;
   logic [LOG2N_W-1:0]  cfg_log2n;
   logic                cmd_busy;
   logic                s_valid;
   logic                s_ready;
   logic [SAMPLE_W-1:0] s_y;
   logic [SAMPLE_W-1:0] s_y_hat;
   logic                start;
   logic [LOG2N_W-1:0]  log2n;
   logic [SAMPLE_W-1:0] y;
   logic [SAMPLE_W-1:0] y_hat;
   logic                next_number;
   logic                done;
   logic [RESULT_W-1:0] result;
   logic                res_valid;
   logic [RESULT_W-1:0] res_data;
   logic                res_ready;
   logic                err_underrun;
   logic                err_overrun;

   modport master (
      input  cmd_start, cfg_log2n, s_valid, s_y, s_y_hat,
      input  next_number, done, result, res_ready,
      output cmd_busy, s_ready, start, log2n, y, y_hat,
      output res_valid, res_data, err_underrun, err_overrun
   );

   modport slave (
      output cmd_start, cfg_log2n, s_valid, s_y, s_y_hat,
      output next_number, done, result, res_ready,
      input  cmd_busy, s_ready, start, log2n, y, y_hat,
      input  res_valid, res_data, err_underrun, err_overrun
   );

endinterface

// File: rtl/cms_pair_fifo.sv
// First-word-fall-through FIFO of (y, y_hat) pairs; head reads as zero when empty.
module cms_pair_fifo
   import cms_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = PAIR_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == {(AW+1){1'b0}});
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/cms_sample_driver.sv
// Initiator-side driver for the ComplexMeanSquare unit: buffers sample pairs,
// launches a run, feeds each request and captures the result for the host.
module cms_sample_driver
   import cms_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   cms_sample_driver_if.master bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LOG2N_W-1:0]  r_log2n;
   logic [REQ_W-1:0]    r_req_cnt;
   logic                r_start;
   logic                r_res_valid;
   logic [RESULT_W-1:0] r_res_data;
   logic                r_err_underrun;
   logic                r_err_overrun;
   logic                w_accept;
   logic                w_req;
   logic                w_over_hit;
   logic                w_done;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [PAIR_W-1:0]   w_head;

   cms_pair_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PAIR_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (bus.s_valid),
      .i_pop   (w_req),
      .i_data  ({bus.s_y, bus.s_y_hat}),
      .o_head  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = (bus.cmd_start && !r_res_valid) ? RUN : IDLE;
         RUN:     w_state_nxt = bus.done ? IDLE : RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Overrun is judged on the count before this request, and does not block the pop.
   always_comb begin
      w_accept   = 1'b0;
      w_req      = 1'b0;
      w_over_hit = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept = bus.cmd_start && !r_res_valid;
         end
         RUN: begin
            w_req      = bus.next_number && !bus.done;
            w_over_hit = bus.next_number && ({1'b0, r_req_cnt} >= run_len(r_log2n));
            w_done     = bus.done;
         end
         default: begin
            w_accept = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_start        <= 1'b0;
         r_log2n        <= {LOG2N_W{1'b0}};
         r_req_cnt      <= {REQ_W{1'b0}};
         r_err_underrun <= 1'b0;
         r_err_overrun  <= 1'b0;
         r_res_valid    <= 1'b0;
         r_res_data     <= {RESULT_W{1'b0}};
      end else begin
         r_start <= (w_state_nxt == RUN);
         if (w_accept) begin
            r_log2n        <= bus.cfg_log2n;
            r_req_cnt      <= {REQ_W{1'b0}};
            r_err_underrun <= 1'b0;
            r_err_overrun  <= 1'b0;
         end else begin
            if (w_req) begin
               r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (w_req && w_fifo_empty) begin
               r_err_underrun <= 1'b1;
            end
            if (w_over_hit) begin
               r_err_overrun <= 1'b1;
            end
         end
         if (w_done) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.result;
         end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign bus.cmd_busy     = (r_state != IDLE);
   assign bus.s_ready      = !w_fifo_full;
   assign bus.start        = r_start;
   assign bus.log2n        = r_log2n;
   assign bus.y            = w_head[PAIR_W-1:SAMPLE_W];
   assign bus.y_hat        = w_head[SAMPLE_W-1:0];
   assign bus.res_valid    = r_res_valid;
   assign bus.res_data     = r_res_data;
   assign bus.err_underrun = r_err_underrun;
   assign bus.err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_cms_sample_driver.sv
// Directed bench for cms_sample_driver with a queue-based reference model
// compared every cycle, plus literal spot checks.
module tb_cms_sample_driver;
   import cms_pkg::*;

   localparam int DEPTH = 8;

   logic clk;
   logic reset;
   int   ntests;
   int   nfail;

   cms_sample_driver_if bus ();

   cms_sample_driver #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] m_q[$];
   bit          m_ready;
   bit          m_run;
   int          m_log2n;
   int          m_req;
   bit          m_res_valid;
   logic [63:0] m_res_data;
   bit          m_uf;
   bit          m_of;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit was_empty;
      bit was_full;
      if (reset) begin
         m_q.delete();
         m_ready = 1'b1; m_run = 1'b0; m_log2n = 0; m_req = 0;
         m_res_valid = 1'b0; m_res_data = 64'd0; m_uf = 1'b0; m_of = 1'b0;
         return;
      end
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() >= DEPTH);
      if (m_run) begin
         if (bus.next_number && m_req >= (1 << m_log2n)) m_of = 1'b1;
         if (bus.next_number && !bus.done) begin
            if (was_empty) m_uf = 1'b1;
            else void'(m_q.pop_front());
            m_req++;
         end
         if (bus.done) begin
            m_run = 1'b0;
            m_res_valid = 1'b1;
            m_res_data = bus.result;
         end else if (bus.res_ready) begin
            m_res_valid = 1'b0;
         end
      end else begin
         if (bus.res_ready) m_res_valid = 1'b0;
         if (bus.cmd_start && !m_res_valid) begin
            m_run = 1'b1; m_log2n = int'(bus.cfg_log2n); m_req = 0;
            m_uf = 1'b0; m_of = 1'b0;
         end
      end
      if (bus.s_valid && !was_full) m_q.push_back({bus.s_y, bus.s_y_hat});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge clk);
      if (m_ready) begin
         check("y",        64'(bus.y),      (m_q.size() > 0) ? 64'(m_q[0][63:32]) : 64'd0);
         check("y_hat",    64'(bus.y_hat),  (m_q.size() > 0) ? 64'(m_q[0][31:0])  : 64'd0);
         check("s_ready",  64'(bus.s_ready), 64'(m_q.size() < DEPTH));
         check("start",    64'(bus.start),   64'(m_run));
         check("cmd_busy", 64'(bus.cmd_busy), 64'(m_run));
         check("log2n",    64'(bus.log2n),   64'(m_log2n));
         check("res_valid", 64'(bus.res_valid), 64'(m_res_valid));
         check("res_data", bus.res_data, m_res_data);
         check("err_underrun", 64'(bus.err_underrun), 64'(m_uf));
         check("err_overrun",  64'(bus.err_overrun),  64'(m_of));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [31:0] yv, input logic [31:0] yh);
      bus.s_valid = 1'b1; bus.s_y = yv; bus.s_y_hat = yh;
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic launch(input logic [2:0] l2);
      bus.cmd_start = 1'b1; bus.cfg_log2n = l2;
      tick();
      bus.cmd_start = 1'b0;
   endtask

   task automatic request();
      bus.next_number = 1'b1;
      tick();
      bus.next_number = 1'b0;
   endtask

   task automatic finish_run(input logic [63:0] res);
      bus.done = 1'b1; bus.result = res;
      tick();
      bus.done = 1'b0;
   endtask

   task automatic ack_result();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   initial begin
      ntests = 0; nfail = 0; m_ready = 1'b0;
      reset = 1'b1;
      bus.cmd_start = 1'b0; bus.cfg_log2n = 3'd0; bus.s_valid = 1'b0;
      bus.s_y = 32'd0; bus.s_y_hat = 32'd0; bus.next_number = 1'b0;
      bus.done = 1'b0; bus.result = 64'd0; bus.res_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_y", 64'(bus.y), 64'd0);
      check("rst_s_ready", 64'(bus.s_ready), 64'd1);
      check("rst_busy", 64'(bus.cmd_busy), 64'd0);

      // Basic run of 8 pairs
      for (int i = 1; i <= 8; i++) push_pair(32'(i), 32'(i + 3));
      launch(3'd3);
      check("basic_start", 64'(bus.start), 64'd1);
      for (int i = 1; i <= 8; i++) begin
         check("basic_y", 64'(bus.y), 64'(i));
         check("basic_y_hat", 64'(bus.y_hat), 64'(i + 3));
         request();
      end
      finish_run(64'd72);
      check("basic_res_valid", 64'(bus.res_valid), 64'd1);
      check("basic_res_data", bus.res_data, 64'd72);
      check("basic_start_low", 64'(bus.start), 64'd0);
      check("basic_empty_y", 64'(bus.y), 64'd0);
      ack_result();

      // Underrun
      push_pair(32'd10, 32'd20);
      push_pair(32'd11, 32'd21);
      launch(3'd2);
      request(); request();
      check("under_y_zero", 64'(bus.y), 64'd0);
      request();
      check("under_flag", 64'(bus.err_underrun), 64'd1);
      finish_run(64'd1);
      ack_result();
      launch(3'd2);
      check("under_clear", 64'(bus.err_underrun), 64'd0);
      finish_run(64'd0);
      ack_result();

      // Overrun: fifth request still pops pair 5
      for (int i = 31; i <= 36; i++) push_pair(32'(i), 32'(i + 100));
      launch(3'd2);
      for (int i = 0; i < 4; i++) request();
      check("over_not_yet", 64'(bus.err_overrun), 64'd0);
      request();
      check("over_flag", 64'(bus.err_overrun), 64'd1);
      check("over_popped", 64'(bus.y), 64'd36);
      finish_run(64'd2);
      ack_result();
      launch(3'd0);
      request();
      finish_run(64'd3);
      ack_result();

      // Backpressure: 9th pair waits for the first pop
      bus.s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.s_y = 32'(40 + i); bus.s_y_hat = 32'(140 + i);
         tick();
      end
      check("bp_full", 64'(bus.s_ready), 64'd0);
      bus.s_y = 32'd48; bus.s_y_hat = 32'd148;
      tick();
      launch(3'd3);
      request();
      check("bp_ready_after_pop", 64'(bus.s_ready), 64'd1);
      tick();
      bus.s_valid = 1'b0;
      check("bp_full_again", 64'(bus.s_ready), 64'd0);
      for (int i = 0; i < 7; i++) request();
      check("bp_ninth_head", 64'(bus.y), 64'd48);
      request();
      finish_run(64'd4);
      ack_result();

      // Result hold blocks a new command
      launch(3'd0);
      finish_run(64'd5);
      launch(3'd1);
      check("hold_ignored", 64'(bus.cmd_busy), 64'd0);
      check("hold_valid", 64'(bus.res_valid), 64'd1);
      ack_result();
      launch(3'd1);
      check("hold_accept", 64'(bus.cmd_busy), 64'd1);

      // Reset mid-run
      for (int i = 50; i < 54; i++) push_pair(32'(i), 32'(i + 7));
      request(); request(); request();
      check("pre_reset_y", 64'(bus.y), 64'd53);
      reset = 1'b1;
      tick();
      check("mid_rst_start", 64'(bus.start), 64'd0);
      check("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
      check("mid_rst_y", 64'(bus.y), 64'd0);
      check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
      reset = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
